align_granule_decoder: RTL and testbench
========================================

Name: align_granule_decoder

Overview:
- Receive-side counterpart of the 16-bit granule rounder.
- The rounder sets bit k (k in 8..11) and clears the bits below it. If it cannot do that, it passes the value through and raises its feeder flag.
- This block accepts the rounded magnitude and the feeder flag over a valid/ready handshake. It serially counts trailing zeros, one bit per cycle, and reports the granule level, the recovered base (granule bit cleared) and a result class.
- Sits between the rounder's output register and downstream datapath/ALU consumers.

Parameters:
- WIDTH, 16, magnitude width.
- MIN_BIT, 8, lowest granule bit position.
- MAX_BIT, 11, highest granule bit position; scan stops here.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  input word present.
- in_ready  output  1  block can accept a word.
- in_mag  input  WIDTH  rounded magnitude.
- in_feeder  input  1  rounder passthrough/overflow flag.
- out_valid  output  1  result present.
- out_ready  input  1  consumer takes the result.
- out_class  output  2  0 ALIGNED, 1 UNALIGNED, 2 NOGRAN, 3 PASS.
- out_tz  output  5  trailing-zero count, capped at MAX_BIT+1.
- out_level  output  2  out_tz - MIN_BIT when ALIGNED, else 0.
- out_base  output  WIDTH  in_mag with bit out_tz cleared when ALIGNED, else in_mag.

Behaviour:
- Reset (async, active-high): state IDLE; in_ready=1 once rst deasserts. All out_* are 0 and the internal shift register and counter are 0.
- Reset mid-SCAN or mid-DONE aborts the word; the word is not replayed.
- FSM states: IDLE, SCAN, DONE. in_ready=1 only in IDLE.
- Accept at edge E0 when in_valid && in_ready; mag is captured into the shift register.
  - in_feeder=1: go to DONE at E0 with class PASS, out_tz=0, out_base=in_mag. No scan is performed.
  - Otherwise: go to SCAN with cnt=0.
- SCAN, one cycle per bit:
  - If sh[0]=1: tz=cnt; go to DONE.
  - Else if cnt==MAX_BIT: tz=MAX_BIT+1; go to DONE with class NOGRAN.
  - Else: shift sh right by 1, cnt+1.
- Classification on DONE entry:
  - tz<MIN_BIT gives UNALIGNED.
  - MIN_BIT<=tz<=MAX_BIT gives ALIGNED.
  - No set bit in [MAX_BIT:0] gives NOGRAN. This includes in_mag=0.
- Latency: out_valid rises after edge E0+tz+1 for scanned words (MAX_BIT+1 = 12 for NOGRAN), and after E0 for PASS.
- DONE: out_valid=1; all out_* are registered and stable until the handshake completes. On out_ready=1, go to IDLE at that edge; out_valid drops.
- Back-to-back transfer is not supported: a new accept is possible no earlier than the cycle after the output handshake.
- out_ready is ignored outside DONE. in_valid is ignored outside IDLE.
- Width rules:
  - out_tz is 5 bits.
  - out_level is the low 2 bits of (tz - MIN_BIT).
  - out_base clears exactly one bit; no carry or borrow.

Optional Feature:
- Macro: ALIGN_DEC_STATS_EN.
- Defined:
  - Adds outputs stat_aligned[7:0] and stat_unaligned[7:0].
  - Each is a saturating counter, incremented once per completed output handshake of that class. Both hold at 255.
  - Cleared by rst.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package align_dec_pkg holds:
  - class enum {ALIGNED, UNALIGNED, NOGRAN, PASS};
  - state enum {IDLE, SCAN, DONE};
  - default MIN_BIT/MAX_BIT constants;
  - TZ_W=5.
- Optional sub-module align_dec_stats holds the saturating counters and is instantiated only under ALIGN_DEC_STATS_EN. The FSM and scan stay in the top module.

Test Plan:
- in_mag=0x0100, feeder=0 -> ALIGNED, tz=8, level=0, base=0x0000; out_valid after E0+9.
- in_mag=0x3800, feeder=0 -> ALIGNED, tz=11, level=3, base=0x3000; out_valid after E0+12.
- in_mag=0x0005 -> UNALIGNED, tz=0, base=0x0005; out_valid after E0+1. in_mag=0x0080 -> UNALIGNED, tz=7, after E0+8.
- in_mag=0x1000 and in_mag=0x0000 -> NOGRAN, tz=12, base=in_mag; out_valid after E0+12.
- in_mag=0xFFFF, feeder=1 -> PASS, base=0xFFFF, after E0. Hold out_ready=0 for 5 cycles -> outputs stable and in_ready=0; release -> IDLE next edge.
- Assert rst during SCAN of 0x0800 -> all outputs 0 immediately, no result emitted, in_ready=1 after release.
- With ALIGN_DEC_STATS_EN: 300 ALIGNED transfers -> stat_aligned=255.

Source files
------------

// File: rtl/align_dec_pkg.sv
// Shared types and default constants for the granule decoder and its stats counters.
package align_dec_pkg;

    localparam int DEF_MIN_BIT = 8;
    localparam int DEF_MAX_BIT = 11;
    localparam int TZ_W        = 5;
    localparam int STAT_W      = 8;

    typedef enum logic [1:0] {
        ALIGNED   = 2'd0,
        UNALIGNED = 2'd1,
        NOGRAN    = 2'd2,
        PASS      = 2'd3
    } class_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/align_dec_stats.sv
// Saturating per-class counters of completed output handshakes (built only with ALIGN_DEC_STATS_EN).
module align_dec_stats
    import align_dec_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              hs,
    input  logic [1:0]        cls,
    output logic [STAT_W-1:0] stat_aligned,
    output logic [STAT_W-1:0] stat_unaligned
);

    localparam logic [STAT_W-1:0] STAT_MAX = '1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_aligned   <= '0;
            stat_unaligned <= '0;
        end else if (hs) begin
            if (cls == ALIGNED && stat_aligned != STAT_MAX)
                stat_aligned <= stat_aligned + STAT_W'(1);
            if (cls == UNALIGNED && stat_unaligned != STAT_MAX)
                stat_unaligned <= stat_unaligned + STAT_W'(1);
        end
    end

endmodule

// File: rtl/align_granule_decoder.sv
// Serial trailing-zero decoder for granule-rounded magnitudes; one bit scanned per cycle.
// Optional per-class handshake counters are enabled by defining ALIGN_DEC_STATS_EN.
module align_granule_decoder
    import align_dec_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int MIN_BIT = DEF_MIN_BIT,
    parameter int MAX_BIT = DEF_MAX_BIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_mag,
    input  logic             in_feeder,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_class,
    output logic [4:0]       out_tz,
    output logic [1:0]       out_level,
    output logic [WIDTH-1:0] out_base
`ifdef ALIGN_DEC_STATS_EN
    ,
    output logic [7:0]       stat_aligned,
    output logic [7:0]       stat_unaligned
`endif
);

    localparam logic [TZ_W-1:0] MIN_TZ  = TZ_W'(MIN_BIT);
    localparam logic [TZ_W-1:0] MAX_TZ  = TZ_W'(MAX_BIT);
    localparam logic [TZ_W-1:0] NOG_TZ  = TZ_W'(MAX_BIT + 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] mag_q, mag_d;
    logic [TZ_W-1:0]  cnt_q, cnt_d;
    class_e           cls_q, cls_d;
    logic [TZ_W-1:0]  tz_q, tz_d;
    logic [1:0]       level_q, level_d;
    logic [WIDTH-1:0] base_q, base_d;

    // NOTE: every comb output gets its hold value first, so no path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        mag_d   = mag_q;
        cnt_d   = cnt_q;
        cls_d   = cls_q;
        tz_d    = tz_q;
        level_d = level_q;
        base_d  = base_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sh_d  = in_mag;
                    mag_d = in_mag;
                    cnt_d = '0;
                    if (in_feeder) begin
                        state_d = DONE;
                        cls_d   = PASS;
                        tz_d    = '0;
                        level_d = '0;
                        base_d  = in_mag;
                    end else begin
                        state_d = SCAN;
                    end
                end
            end

            SCAN: begin
                if (sh_q[0]) begin
                    state_d = DONE;
                    tz_d    = cnt_q;
                    if (cnt_q < MIN_TZ) begin
                        cls_d   = UNALIGNED;
                        level_d = '0;
                        base_d  = mag_q;
                    end else begin
                        cls_d   = ALIGNED;
                        // low bits of the difference only depend on the low bits of the operands
                        level_d = cnt_q[1:0] - MIN_TZ[1:0];
                        base_d  = mag_q & ~(WIDTH'(1) << cnt_q);
                    end
                end else if (cnt_q == MAX_TZ) begin
                    state_d = DONE;
                    cls_d   = NOGRAN;
                    tz_d    = NOG_TZ;
                    level_d = '0;
                    base_d  = mag_q;
                end else begin
                    sh_d  = sh_q >> 1;
                    cnt_d = cnt_q + TZ_W'(1);
                end
            end

            DONE: begin
                if (out_ready)
                    state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sh_q    <= '0;
            mag_q   <= '0;
            cnt_q   <= '0;
            cls_q   <= ALIGNED;
            tz_q    <= '0;
            level_q <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            mag_q   <= mag_d;
            cnt_q   <= cnt_d;
            cls_q   <= cls_d;
            tz_q    <= tz_d;
            level_q <= level_d;
            base_q  <= base_d;
        end
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign out_class = cls_q;
    assign out_tz    = tz_q;
    assign out_level = level_q;
    assign out_base  = base_q;

`ifdef ALIGN_DEC_STATS_EN
    logic xfer_done;
    assign xfer_done = out_valid && out_ready;

    align_dec_stats u_stats (
        .clk            (clk),
        .rst            (rst),
        .hs             (xfer_done),
        .cls            (out_class),
        .stat_aligned   (stat_aligned),
        .stat_unaligned (stat_unaligned)
    );
`endif

endmodule

// File: tb/tb_align_granule_decoder.sv
// Directed bench for align_granule_decoder: latency, classification, hold, reset abort, optional stats.
module tb_align_granule_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_mag;
    logic        in_feeder;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_class;
    logic [4:0]  out_tz;
    logic [1:0]  out_level;
    logic [15:0] out_base;
`ifdef ALIGN_DEC_STATS_EN
    logic [7:0]  stat_aligned;
    logic [7:0]  stat_unaligned;
`endif

    int total = 0;
    int bad   = 0;

    align_granule_decoder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mag    (in_mag),
        .in_feeder (in_feeder),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_class (out_class),
        .out_tz    (out_tz),
        .out_level (out_level),
        .out_base  (out_base)
`ifdef ALIGN_DEC_STATS_EN
        ,
        .stat_aligned   (stat_aligned),
        .stat_unaligned (stat_unaligned)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one word, measure edges from accept to out_valid, check the result,
    // hold out_ready low for 'hold' cycles, then complete the handshake.
    task automatic run_word(input string tag, input logic [15:0] mag, input logic feeder,
                            input int exp_lat, input logic [1:0] exp_cls, input logic [4:0] exp_tz,
                            input logic [1:0] exp_lvl, input logic [15:0] exp_base, input int hold);
        int n;
        check({tag, ".ready_before"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        in_mag    = mag;
        in_feeder = feeder;
        tick();
        in_valid  = 1'b0;
        in_mag    = 16'hA5A5;
        in_feeder = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, ".latency"}, 32'(n), 32'(exp_lat));
        check({tag, ".valid"}, 32'(out_valid), 32'd1);
        check({tag, ".class"}, 32'(out_class), 32'(exp_cls));
        check({tag, ".tz"}, 32'(out_tz), 32'(exp_tz));
        check({tag, ".level"}, 32'(out_level), 32'(exp_lvl));
        check({tag, ".base"}, 32'(out_base), 32'(exp_base));
        check({tag, ".ready_busy"}, 32'(in_ready), 32'd0);
        for (int h = 0; h < hold; h++) begin
            tick();
            check({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, ".hold_base"}, 32'(out_base), 32'(exp_base));
            check({tag, ".hold_class"}, 32'(out_class), 32'(exp_cls));
            check({tag, ".hold_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, ".valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, ".ready_after"}, 32'(in_ready), 32'd1);
    endtask

    // Unchecked transfer used to drive the stats counters.
    task automatic quiet_word(input logic [15:0] mag);
        int n;
        in_valid  = 1'b1;
        in_mag    = mag;
        in_feeder = 1'b0;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        int seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_mag    = '0;
        in_feeder = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst.valid", 32'(out_valid), 32'd0);
        check("rst.class", 32'(out_class), 32'd0);
        check("rst.tz", 32'(out_tz), 32'd0);
        check("rst.level", 32'(out_level), 32'd0);
        check("rst.base", 32'(out_base), 32'd0);
        rst = 1'b0;
        #1;
        check("rst.ready", 32'(in_ready), 32'd1);
        tick();

        run_word("al_0100", 16'h0100, 1'b0, 9, 2'd0, 5'd8, 2'd0, 16'h0000, 0);
        run_word("al_3800", 16'h3800, 1'b0, 12, 2'd0, 5'd11, 2'd3, 16'h3000, 0);
        run_word("un_0005", 16'h0005, 1'b0, 1, 2'd1, 5'd0, 2'd0, 16'h0005, 0);
        run_word("un_0080", 16'h0080, 1'b0, 8, 2'd1, 5'd7, 2'd0, 16'h0080, 0);
        run_word("ng_1000", 16'h1000, 1'b0, 12, 2'd2, 5'd12, 2'd0, 16'h1000, 0);
        run_word("ng_0000", 16'h0000, 1'b0, 12, 2'd2, 5'd12, 2'd0, 16'h0000, 0);
        run_word("ps_ffff", 16'hFFFF, 1'b1, 0, 2'd3, 5'd0, 2'd0, 16'hFFFF, 5);

        // Abort a scan of 0x0800 with reset; outputs still hold the 0xFFFF PASS result beforehand.
        in_valid  = 1'b1;
        in_mag    = 16'h0800;
        in_feeder = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("abort.valid", 32'(out_valid), 32'd0);
        check("abort.class", 32'(out_class), 32'd0);
        check("abort.tz", 32'(out_tz), 32'd0);
        check("abort.base", 32'(out_base), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("abort.ready", 32'(in_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check("abort.no_result", 32'(seen), 32'd0);

        run_word("al_0c00", 16'h0C00, 1'b0, 11, 2'd0, 5'd10, 2'd2, 16'h0800, 0);

`ifdef ALIGN_DEC_STATS_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("stats.rst_al", 32'(stat_aligned), 32'd0);
        check("stats.rst_un", 32'(stat_unaligned), 32'd0);
        for (int i = 0; i < 300; i++)
            quiet_word(16'h0100);
        quiet_word(16'h0003);
        quiet_word(16'h0000);
        check("stats.al_sat", 32'(stat_aligned), 32'd255);
        check("stats.un_one", 32'(stat_unaligned), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
